// File: rtl/mips_pkg.sv
// mips_pkg: shared widths and state/owner encodings for the data-memory path
package mips_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;
    typedef enum logic {OWN_CPU, OWN_DBG} owner_t;
endpackage

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr: saturating wait counter that flags when the debug port must win
module arb_starve_ctr #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic sat
);
    localparam int W = $clog2(MAX + 1);
    logic [W-1:0] cnt;
    // count waiting cycles up to the limit, restart whenever the debug port is granted
    always_ff @(posedge clk) begin
        if (reset || clr) cnt <= '0;
        else if (inc && !sat) cnt <= cnt + 1'b1;
    end
    assign sat = cnt >= W'(MAX);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares single-port dmem between the MEM stage and the debug/loader port
module dmem_arbiter #(
    parameter int ADDR_W     = mips_pkg::ADDR_W,
    parameter int DATA_W     = mips_pkg::DATA_W,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_err,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [31:0]       dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_done,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    import mips_pkg::*;
    localparam int LW = $clog2(MEM_LAT + 1);
    state_t state, nxt;
    owner_t owner;
    logic we_r, mis_r, sat, grant_dbg, go, resp;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r, rd;
    logic [LW-1:0] lat;
    logic [31:0] sel_addr;
    logic unused_hi;
    assign grant_dbg = dbg_req & (sat | ~cpu_req);
    assign go = state == ST_IDLE && (cpu_req || dbg_req);
    assign sel_addr = grant_dbg ? dbg_addr : cpu_addr;
    assign unused_hi = ^{cpu_addr[31:ADDR_W+2], dbg_addr[31:ADDR_W+2]};
    assign cpu_stall = cpu_req & ~cpu_done;
    arb_starve_ctr #(.MAX(STARVE_MAX)) u_ctr (
        .clk(clk),
        .reset(reset),
        .inc(dbg_req & ~(state != ST_IDLE && owner == OWN_DBG)),
        .clr(go & grant_dbg),
        .sat(sat)
    );
    // state register plus the granted request, latched once in the arbitration cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            owner   <= OWN_CPU;
            we_r    <= 1'b0;
            mis_r   <= 1'b0;
            addr_r  <= '0;
            wdata_r <= '0;
            lat     <= '0;
        end else begin
            state <= nxt;
            lat   <= state == ST_WAIT ? lat + 1'b1 : '0;
            if (go) begin
                owner   <= grant_dbg ? OWN_DBG : OWN_CPU;
                we_r    <= grant_dbg ? dbg_we : cpu_we;
                mis_r   <= |sel_addr[1:0];
                addr_r  <= sel_addr[ADDR_W+1:2];
                wdata_r <= grant_dbg ? dbg_wdata : cpu_wdata;
            end
        end
    end
    // next state, memory strobe and per-port response steering
    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:  nxt = go ? (|sel_addr[1:0] ? ST_RESP : ST_ISSUE) : ST_IDLE;
            ST_ISSUE: nxt = MEM_LAT == 1 ? ST_RESP : ST_WAIT;
            ST_WAIT:  nxt = lat == LW'(MEM_LAT - 2) ? ST_RESP : ST_WAIT;
            default:  nxt = ST_IDLE;
        endcase
        mem_en    = state == ST_ISSUE;
        mem_we    = mem_en & we_r;
        mem_addr  = mem_en ? addr_r : '0;
        mem_wdata = mem_en ? wdata_r : '0;
        resp      = state == ST_RESP;
        rd        = (we_r | mis_r) ? '0 : mem_rdata;
        cpu_done  = resp & (owner == OWN_CPU);
        dbg_done  = resp & (owner == OWN_DBG);
        cpu_err   = cpu_done & mis_r;
        dbg_err   = dbg_done & mis_r;
        cpu_rdata = cpu_done ? rd : '0;
        dbg_rdata = dbg_done ? rd : '0;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized two-port traffic checked against a transaction-timing model
module tb_dmem_arbiter;
    localparam int AW = 5, DW = 32, LAT = 1, SMAX = 4, NCYC = 4500;
    logic clk = 0, reset = 1;
    logic [1:0] rq = 0, wev = 0;
    logic [31:0] ad [2];
    logic [31:0] wdv [2];
    logic cpu_done, cpu_err, cpu_stall, dbg_done, dbg_err, mem_en, mem_we;
    logic [DW-1:0] cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] dmem [32];
    logic [DW-1:0] rpipe [LAT];
    logic loaded = 0;
    int n_chk = 0, n_fail = 0;
    always #5 clk = ~clk;
    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(rq[0]), .cpu_we(wev[0]), .cpu_addr(ad[0]), .cpu_wdata(wdv[0]),
        .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err), .cpu_stall(cpu_stall),
        .dbg_req(rq[1]), .dbg_we(wev[1]), .dbg_addr(ad[1]), .dbg_wdata(wdv[1]),
        .dbg_done(dbg_done), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );
    // behavioural dmem: preloaded with i*0x11, read data appears LAT cycles after the access
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 32; i++) dmem[i] <= i * 32'h11;
            loaded <= 1;
        end else if (mem_en && mem_we) dmem[mem_addr] <= mem_wdata;
        rpipe[0] <= dmem[mem_addr];
        for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign mem_rdata = rpipe[LAT-1];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    logic [DW-1:0] ref_mem [32];
    bit m_busy, m_we, m_mis, post_rst;
    int m_k, m_own, m_addr, sc;
    logic [DW-1:0] m_wd;
    logic [1:0] done_prev;
    int waitc [2];
    int p_start [2];
    int p_hold, mis_div, wmax, p_rst;

    function automatic int tend();
        return m_mis ? 1 : 1 + LAT;
    endfunction

    task automatic new_fields(input int p);
        logic [1:0] off;
        off = ($urandom % mis_div == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
        wev[p] = 1'($urandom % 2);
        ad[p] = ($urandom & 32'hFFFF_FF80) | (32'($urandom_range(0, wmax)) << 2) | 32'(off);
        wdv[p] = $urandom;
    endtask

    task automatic drive(input int c);
        p_start[0] = c < 1500 ? 40 : c < 3000 ? 100 : 50;
        p_start[1] = c < 1500 ? 40 : 50;
        p_hold     = c < 1500 ? 30 : c < 3000 ? 100 : 40;
        mis_div    = c < 3000 ? 6 : 3;
        wmax       = c < 3000 ? 31 : 3;
        p_rst      = c < 3000 ? 0 : 10;
        for (int p = 0; p < 2; p++) begin
            if (rq[p] && done_prev[p]) begin
                if ($urandom_range(0, 99) < p_hold) new_fields(p);
                else rq[p] = 0;
            end else if (!rq[p] && c >= 3 && $urandom_range(0, 99) < p_start[p]) begin
                rq[p] = 1;
                new_fields(p);
            end
            waitc[p] = (rq[p] && !done_prev[p]) ? waitc[p] + 1 : 0;
        end
        reset = c < 3 || (m_busy && m_k == 1 && m_we && !m_mis && $urandom_range(0, 99) < p_rst)
                || $urandom_range(0, 499) == 0;
    endtask

    task automatic check();
        bit issue, resp, ed;
        logic [1:0] gd, ge;
        logic [DW-1:0] gr [2];
        gd = {dbg_done, cpu_done};
        ge = {dbg_err, cpu_err};
        gr[0] = cpu_rdata;
        gr[1] = dbg_rdata;
        issue = m_busy && !m_mis && m_k == 1;
        resp = m_busy && m_k == tend();
        chk("mem_en", 32'(mem_en), 32'(issue));
        if (issue) begin
            chk("mem_we", 32'(mem_we), 32'(m_we));
            chk("mem_addr", 32'(mem_addr), 32'(m_addr));
            chk("mem_wdata", mem_wdata, m_wd);
        end
        for (int p = 0; p < 2; p++) begin
            ed = resp && m_own == p;
            chk(p ? "dbg_done" : "cpu_done", 32'(gd[p]), 32'(ed));
            chk(p ? "dbg_err" : "cpu_err", 32'(ge[p]), 32'(ed && m_mis));
            if (ed && !m_mis) chk(p ? "dbg_rdata" : "cpu_rdata", gr[p], m_we ? 32'd0 : ref_mem[m_addr]);
            if (resp && !ed) chk(p ? "dbg_rdata_idle" : "cpu_rdata_idle", gr[p], 32'd0);
            chk(p ? "dbg_wait_bound" : "cpu_wait_bound", 32'(waitc[p] < 40), 32'd1);
        end
        chk("cpu_stall", 32'(cpu_stall), 32'(rq[0] && !(resp && m_own == 0)));
        if (post_rst) begin
            chk("rst_strobes", {26'd0, cpu_done, cpu_err, dbg_done, dbg_err, mem_en, mem_we}, 32'd0);
            chk("rst_rdata", cpu_rdata | dbg_rdata, 32'd0);
            chk("rst_mem_bus", mem_wdata | 32'(mem_addr), 32'd0);
        end
        done_prev = gd;
        if (issue && m_we) ref_mem[m_addr] = m_wd;
    endtask

    task automatic advance();
        bit gdb;
        int p;
        if (reset) begin
            m_busy = 0;
            sc = 0;
        end else if (!m_busy && rq != 0) begin
            gdb = rq[1] && (sc >= SMAX || !rq[0]);
            sc = gdb ? 0 : (rq[1] && sc < SMAX) ? sc + 1 : sc;
            p = gdb ? 1 : 0;
            m_own = p;
            m_we = wev[p];
            m_mis = ad[p][1:0] != 2'd0;
            m_addr = int'(ad[p][6:2]);
            m_wd = wdv[p];
            m_busy = 1;
            m_k = 1;
        end else begin
            if (rq[1] && !(m_busy && m_own == 1) && sc < SMAX) sc++;
            if (m_busy) begin
                if (m_k == tend()) m_busy = 0;
                else m_k++;
            end
        end
        post_rst = reset;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ref_mem[i] = i * 32'h11;
        for (int p = 0; p < 2; p++) begin
            ad[p] = 0;
            wdv[p] = 0;
            waitc[p] = 0;
        end
        done_prev = 0;
        m_busy = 0;
        post_rst = 0;
        sc = 0;
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            drive(c);
            @(negedge clk);
            check();
            advance();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
